// File: rtl/dram_bank_sched.sv
// DRAM bank scheduler core with an open-page policy.
// Takes {bank,row,col} requests over valid/ready, keeps an open-row table per
// bank, sequences PRE/ACT/RD/WR/REF with programmable timing and owns the
// periodic refresh. Every output comes straight from a flop: the combinational
// block computes what the next cycle shows, and the output registers load it.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is only high in IDLE with no refresh
// pending; once transferred, bank/row/col/we are held internally, so req_addr
// and req_we may change freely afterwards.
module dram_bank_sched #(
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8,
  parameter int BURST_LEN    = 4,
  parameter int T_RCD        = 2,
  parameter int T_RP         = 2,
  parameter int T_RFC        = 8,
  parameter int REF_INTERVAL = 1024,
  localparam int BANK_W = $clog2(NUM_OF_BANKS),
  localparam int ROW_W  = $clog2(NUM_OF_ROWS),
  localparam int COL_W  = $clog2(NUM_OF_COLS),
  localparam int ADDR_W = BANK_W + ROW_W + COL_W
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_W-1:0]       req_addr,
  output logic [2:0]              cmd,
  output logic [NUM_OF_BANKS-1:0] bank_sel,
  output logic [NUM_OF_ROWS-1:0]  row_sel,
  output logic [NUM_OF_COLS-1:0]  col_sel,
  output logic                    data_phase,
  output logic                    req_done,
  output logic                    refresh_busy,
  output logic [3:0]              fsm_state
);

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  // Wait counter must hold the largest of the timing values.
  localparam int T_MAX0 = (T_RP > T_RCD) ? T_RP : T_RCD;
  localparam int T_MAX  = (T_MAX0 > T_RFC) ? T_MAX0 : T_RFC;
  localparam int CNT_W  = (T_MAX > 1) ? $clog2(T_MAX + 1) : 1;
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int RC_W   = $clog2(REF_INTERVAL);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_PRE       = 4'd1,
    S_PRE_WAIT  = 4'd2,
    S_ACT       = 4'd3,
    S_ACT_WAIT  = 4'd4,
    S_BURST     = 4'd5,
    S_RPRE      = 4'd6,
    S_RPRE_WAIT = 4'd7,
    S_REF       = 4'd8,
    S_REF_WAIT  = 4'd9
  } state_t;

  state_t              state_q, state_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic [BEAT_W-1:0]   beat_q, beat_n;

  logic [BANK_W-1:0]   bank_q;
  logic [ROW_W-1:0]    row_q;
  logic [COL_W-1:0]    col_q;
  logic                we_q;

  logic [NUM_OF_BANKS-1:0] open_q;
  logic [ROW_W-1:0]        open_row_q [NUM_OF_BANKS];

  logic [RC_W-1:0]     ref_cnt_q;
  logic                ref_pend_q, ref_pend_n;
  logic                ref_clr;
  logic                ref_wrap;

  logic                accept;
  logic [BANK_W-1:0]   a_bank;
  logic [ROW_W-1:0]    a_row;
  logic [COL_W-1:0]    a_col;

  logic [BANK_W-1:0]   tgt_bank;
  logic [ROW_W-1:0]    tgt_row;
  logic [COL_W-1:0]    tgt_col;
  logic                tgt_we;

  logic                    ready_n;
  logic [2:0]              cmd_n;
  logic [NUM_OF_BANKS-1:0] bank_sel_n;
  logic [NUM_OF_ROWS-1:0]  row_sel_n;
  logic [NUM_OF_COLS-1:0]  col_sel_n;
  logic                    data_phase_n;
  logic                    req_done_n;
  logic                    busy_n;

  assign accept   = req_valid & req_ready;
  assign a_bank   = req_addr[ADDR_W-1 -: BANK_W];
  assign a_row    = req_addr[COL_W +: ROW_W];
  assign a_col    = req_addr[COL_W-1:0];
  assign ref_wrap = (ref_cnt_q == RC_W'(REF_INTERVAL - 1));

  // In IDLE the target is the request on the bus; afterwards it is the held copy.
  assign tgt_bank = (state_q == S_IDLE) ? a_bank : bank_q;
  assign tgt_row  = (state_q == S_IDLE) ? a_row  : row_q;
  assign tgt_col  = (state_q == S_IDLE) ? a_col  : col_q;
  assign tgt_we   = (state_q == S_IDLE) ? req_we : we_q;

  // Next-state logic: refresh first, then row hit / closed bank / row conflict.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    beat_n  = beat_q;
    ref_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ref_pend_q) begin
          state_n = (|open_q) ? S_RPRE : S_REF;
        end else if (accept) begin
          if (open_q[a_bank] && (open_row_q[a_bank] == a_row)) begin
            state_n = S_BURST;
            beat_n  = '0;
          end else if (open_q[a_bank]) begin
            state_n = S_PRE;
          end else begin
            state_n = S_ACT;
          end
        end
      end
      S_PRE: begin
        if (T_RP > 1) begin
          state_n = S_PRE_WAIT;
          cnt_n   = CNT_W'(T_RP - 2);
        end else begin
          state_n = S_ACT;
        end
      end
      S_PRE_WAIT: begin
        if (cnt_q == '0) state_n = S_ACT;
        else             cnt_n   = cnt_q - 1'b1;
      end
      S_ACT: begin
        if (T_RCD > 1) begin
          state_n = S_ACT_WAIT;
          cnt_n   = CNT_W'(T_RCD - 2);
        end else begin
          state_n = S_BURST;
          beat_n  = '0;
        end
      end
      S_ACT_WAIT: begin
        if (cnt_q == '0) begin
          state_n = S_BURST;
          beat_n  = '0;
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      S_BURST: begin
        if (beat_q == BEAT_W'(BURST_LEN - 1)) state_n = S_IDLE;
        else                                   beat_n  = beat_q + 1'b1;
      end
      S_RPRE: begin
        if (T_RP > 1) begin
          state_n = S_RPRE_WAIT;
          cnt_n   = CNT_W'(T_RP - 2);
        end else begin
          state_n = S_REF;
        end
      end
      S_RPRE_WAIT: begin
        if (cnt_q == '0) state_n = S_REF;
        else             cnt_n   = cnt_q - 1'b1;
      end
      S_REF: begin
        if (T_RFC > 1) begin
          state_n = S_REF_WAIT;
          cnt_n   = CNT_W'(T_RFC - 2);
        end else begin
          state_n = S_IDLE;
          ref_clr = 1'b1;
        end
      end
      S_REF_WAIT: begin
        if (cnt_q == '0) begin
          state_n = S_IDLE;
          ref_clr = 1'b1;
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // A fresh expiry wins over the clear so a refresh is never lost.
  always_comb begin
    ref_pend_n = ref_pend_q;
    if (ref_wrap)     ref_pend_n = 1'b1;
    else if (ref_clr) ref_pend_n = 1'b0;
  end

  // Output values for the cycle the FSM is about to enter.
  always_comb begin
    cmd_n        = CMD_NOP;
    bank_sel_n   = '0;
    row_sel_n    = '0;
    col_sel_n    = '0;
    data_phase_n = 1'b0;
    req_done_n   = 1'b0;
    busy_n       = 1'b0;
    ready_n      = (state_n == S_IDLE) && !ref_pend_n;
    case (state_n)
      S_PRE: begin
        cmd_n      = CMD_PRE;
        bank_sel_n = NUM_OF_BANKS'(1) << tgt_bank;
      end
      S_ACT: begin
        cmd_n      = CMD_ACT;
        bank_sel_n = NUM_OF_BANKS'(1) << tgt_bank;
        row_sel_n  = NUM_OF_ROWS'(1) << tgt_row;
      end
      S_BURST: begin
        cmd_n        = tgt_we ? CMD_WR : CMD_RD;
        bank_sel_n   = NUM_OF_BANKS'(1) << tgt_bank;
        row_sel_n    = NUM_OF_ROWS'(1) << tgt_row;
        col_sel_n    = NUM_OF_COLS'(1) << COL_W'(tgt_col + COL_W'(beat_n));
        data_phase_n = 1'b1;
        req_done_n   = (beat_n == BEAT_W'(BURST_LEN - 1));
      end
      S_RPRE: begin
        cmd_n      = CMD_PRE;
        bank_sel_n = '1;
        busy_n     = 1'b1;
      end
      S_REF: begin
        cmd_n      = CMD_REF;
        bank_sel_n = '1;
        busy_n     = 1'b1;
      end
      S_RPRE_WAIT, S_REF_WAIT: busy_n = 1'b1;
      default: ;
    endcase
  end

  // FSM state, wait counter and beat counter.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      beat_q  <= beat_n;
    end
  end

  // Hold the accepted request for the rest of its sequence.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      bank_q <= '0;
      row_q  <= '0;
      col_q  <= '0;
      we_q   <= 1'b0;
    end else if (accept) begin
      bank_q <= a_bank;
      row_q  <= a_row;
      col_q  <= a_col;
      we_q   <= req_we;
    end
  end

  // Open-row table: PRE closes one bank, ACT opens a row, refresh PRE closes all.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      open_q <= '0;
      for (int i = 0; i < NUM_OF_BANKS; i++) open_row_q[i] <= '0;
    end else begin
      if (state_n == S_RPRE) begin
        open_q <= '0;
      end else if (state_n == S_PRE) begin
        open_q[tgt_bank] <= 1'b0;
      end else if (state_n == S_ACT) begin
        open_q[tgt_bank]     <= 1'b1;
        open_row_q[tgt_bank] <= tgt_row;
      end
    end
  end

  // Free-running refresh interval counter and the pending flag.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
    end else begin
      ref_cnt_q  <= ref_wrap ? '0 : ref_cnt_q + 1'b1;
      ref_pend_q <= ref_pend_n;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      req_ready    <= 1'b0;
      cmd          <= CMD_NOP;
      bank_sel     <= '0;
      row_sel      <= '0;
      col_sel      <= '0;
      data_phase   <= 1'b0;
      req_done     <= 1'b0;
      refresh_busy <= 1'b0;
    end else begin
      req_ready    <= ready_n;
      cmd          <= cmd_n;
      bank_sel     <= bank_sel_n;
      row_sel      <= row_sel_n;
      col_sel      <= col_sel_n;
      data_phase   <= data_phase_n;
      req_done     <= req_done_n;
      refresh_busy <= busy_n;
    end
  end

  assign fsm_state = state_q;

endmodule

// File: tb/tb_dram_bank_sched.sv
// Directed bench for dram_bank_sched: row hit / closed / conflict timing,
// column wrap, refresh with held request, refresh during a burst, and
// asynchronous reset in the middle of an ACT wait.
module tb_dram_bank_sched;

  localparam int NB   = 8;
  localparam int NR   = 128;
  localparam int NC   = 8;
  localparam int BL   = 4;
  localparam int TRCD = 2;
  localparam int TRP  = 2;
  localparam int TRFC = 8;
  localparam int RI   = 64;
  localparam int BW   = $clog2(NB);
  localparam int RW   = $clog2(NR);
  localparam int CW   = $clog2(NC);
  localparam int AW   = BW + RW + CW;

  localparam logic [2:0] C_NOP = 3'd0;
  localparam logic [2:0] C_ACT = 3'd1;
  localparam logic [2:0] C_RD  = 3'd2;
  localparam logic [2:0] C_WR  = 3'd3;
  localparam logic [2:0] C_PRE = 3'd4;
  localparam logic [2:0] C_REF = 3'd5;

  logic          clk;
  logic          rst_b;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [2:0]    cmd;
  logic [NB-1:0] bank_sel;
  logic [NR-1:0] row_sel;
  logic [NC-1:0] col_sel;
  logic          data_phase;
  logic          req_done;
  logic          refresh_busy;
  logic [3:0]    fsm_state;

  int            total;
  int            bad;
  logic [31:0]   cyc;

  dram_bank_sched #(
    .NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC), .BURST_LEN(BL),
    .T_RCD(TRCD), .T_RP(TRP), .T_RFC(TRFC), .REF_INTERVAL(RI)
  ) dut (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .cmd(cmd), .bank_sel(bank_sel),
    .row_sel(row_sel), .col_sel(col_sel), .data_phase(data_phase),
    .req_done(req_done), .refresh_busy(refresh_busy), .fsm_state(fsm_state)
  );

  // Clock and cycle count since reset release.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) cyc <= '0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NB-1:0] oh_b(input int i);
    logic [NB-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [NR-1:0] oh_r(input int i);
    logic [NR-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [NC-1:0] oh_c(input int i);
    logic [NC-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Check every output in the current cycle, then move to the next negedge.
  task automatic exp_cyc(input string tag, input logic [2:0] c, input logic [NB-1:0] b,
                         input logic [NR-1:0] r, input logic [NC-1:0] k, input logic dp,
                         input logic dn, input logic bz, input logic rd);
    chk({tag, ".cmd"},   256'(cmd),          256'(c));
    chk({tag, ".bank"},  256'(bank_sel),     256'(b));
    chk({tag, ".row"},   256'(row_sel),      256'(r));
    chk({tag, ".col"},   256'(col_sel),      256'(k));
    chk({tag, ".dp"},    256'(data_phase),   256'(dp));
    chk({tag, ".done"},  256'(req_done),     256'(dn));
    chk({tag, ".busy"},  256'(refresh_busy), 256'(bz));
    chk({tag, ".ready"}, 256'(req_ready),    256'(rd));
    @(negedge clk);
  endtask

  task automatic nop(input string tag, input logic bz, input logic rd);
    exp_cyc(tag, C_NOP, '0, '0, '0, 1'b0, 1'b0, bz, rd);
  endtask

  // Present a request at this negedge; returns at the negedge of cycle 1.
  task automatic issue(input logic we, input int b, input int r, input int c);
    chk("issue.ready", 256'(req_ready), 256'(1));
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = {BW'(b), RW'(r), CW'(c)};
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = AW'($urandom_range(0, (1 << AW) - 1));
  endtask

  task automatic burst(input string tag, input logic [2:0] c, input int b, input int r, input int c0);
    for (int k = 0; k < BL; k++)
      exp_cyc(tag, c, oh_b(b), oh_r(r), oh_c((c0 + k) % NC), 1'b1, (k == BL - 1), 1'b0, 1'b0);
  endtask

  task automatic act(input string tag, input int b, input int r);
    exp_cyc(tag, C_ACT, oh_b(b), oh_r(r), '0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (TRCD - 1) nop({tag, ".trcd"}, 1'b0, 1'b0);
  endtask

  task automatic rf_seq(input string tag, input logic pre);
    if (pre) begin
      exp_cyc({tag, ".pre"}, C_PRE, '1, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (TRP - 1) nop({tag, ".trp"}, 1'b1, 1'b0);
    end
    exp_cyc({tag, ".ref"}, C_REF, '1, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (TRFC - 1) nop({tag, ".trfc"}, 1'b1, 1'b0);
  endtask

  task automatic wait_cyc(input int t);
    int n;
    n = 0;
    while (cyc < 32'(t) && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk("align", 256'(cyc), 256'(t));
  endtask

  // Directed sequence.
  initial begin
    total     = 0;
    bad       = 0;
    rst_b     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    repeat (3) @(negedge clk);
    nop("reset", 1'b0, 1'b0);
    rst_b = 1'b1;
    @(negedge clk);
    nop("idle0", 1'b0, 1'b1);

    // Closed bank: ACT at 1, WR from 1+T_RCD, columns 3..6.
    issue(1'b1, 0, 5, 3);
    act("w_act", 0, 5);
    burst("w_burst", C_WR, 0, 5, 3);
    nop("idle1", 1'b0, 1'b1);

    // Row hit: RD at 1, column wraps 6,7,0,1.
    issue(1'b0, 0, 5, 6);
    burst("hit", C_RD, 0, 5, 6);
    nop("idle2", 1'b0, 1'b1);

    // Row conflict: PRE at 1, ACT at 1+T_RP, RD at 1+T_RP+T_RCD.
    issue(1'b0, 0, 9, 0);
    exp_cyc("conf_pre", C_PRE, oh_b(0), '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (TRP - 1) nop("conf_trp", 1'b0, 1'b0);
    act("conf_act", 0, 9);
    burst("conf_rd", C_RD, 0, 9, 0);
    nop("idle3", 1'b0, 1'b1);

    // Highest bank and row, column wrap from the last column.
    issue(1'b1, NB - 1, NR - 1, NC - 1);
    act("edge_act", NB - 1, NR - 1);
    burst("edge_wr", C_WR, NB - 1, NR - 1, NC - 1);
    nop("idle4", 1'b0, 1'b1);

    // Refresh expiry, request held throughout and only accepted afterwards.
    wait_cyc(RI);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = {BW'(0), RW'(9), CW'(2)};
    nop("rf1_pend", 1'b0, 1'b0);
    rf_seq("rf1", 1'b1);
    nop("rf1_done", 1'b0, 1'b1);
    req_valid = 1'b0;
    act("rf1_act", 0, 9);
    burst("rf1_rd", C_RD, 0, 9, 2);
    nop("idle5", 1'b0, 1'b1);

    // Refresh expiring mid-burst: burst completes, then refresh, no accept between.
    wait_cyc(2 * RI - 3);
    issue(1'b0, 0, 9, 5);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = {BW'(5), RW'(3), CW'(0)};
    burst("rf2_burst", C_RD, 0, 9, 5);
    nop("rf2_pend", 1'b0, 1'b0);
    rf_seq("rf2", 1'b1);
    nop("rf2_done", 1'b0, 1'b1);
    req_valid = 1'b0;
    act("rf2_act", 5, 3);
    burst("rf2_wr", C_WR, 5, 3, 0);
    nop("idle6", 1'b0, 1'b1);

    // Asynchronous reset during the ACT wait clears outputs and the open-row table.
    issue(1'b1, 2, 1, 4);
    exp_cyc("ra_act", C_ACT, oh_b(2), oh_r(1), '0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_b = 1'b0;
    #1;
    chk("rst_async.cmd",   256'(cmd),          256'(C_NOP));
    chk("rst_async.bank",  256'(bank_sel),     256'(0));
    chk("rst_async.row",   256'(row_sel),      256'(0));
    chk("rst_async.ready", 256'(req_ready),    256'(0));
    chk("rst_async.busy",  256'(refresh_busy), 256'(0));
    chk("rst_async.state", 256'(fsm_state),    256'(0));
    @(negedge clk);
    nop("rst_hold", 1'b0, 1'b0);
    rst_b = 1'b1;
    @(negedge clk);
    nop("idle7", 1'b0, 1'b1);
    issue(1'b0, 5, 3, 1);
    act("post_rst_act", 5, 3);
    burst("post_rst_rd", C_RD, 5, 3, 1);
    nop("idle8", 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
